// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequences the systolic array through clear, feed, drain and write-back phases.
module matmul_seq_ctrl #(
  parameter int MAX_DIM     = 4,
  parameter int DIM_W       = $clog2(MAX_DIM),
  parameter int SP_NTARGETS = 4,
  parameter int SP_W        = $clog2(SP_NTARGETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] dim_n_i,
  input  logic [DIM_W-1:0] dim_k_i,
  input  logic [DIM_W-1:0] dim_m_i,
  input  logic [SP_W-1:0]  sp_target_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_err_o,
  output logic             array_clear_o,
  output logic             feed_valid_o,
  output logic [DIM_W-1:0] feed_idx_o,
  output logic             sp_we_o,
  output logic [SP_W-1:0]  sp_addr_o
);
  localparam int CW = DIM_W + 2;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, drain_len;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d, feed_idx_d;
  logic [SP_W-1:0] tgt_q, tgt_d, sp_addr_d;
  logic busy_d, done_d, start_err_d, array_clear_d, feed_valid_d, sp_we_d;
  // dims are held as (value - 1), so their sum is exactly N+M-2 drain cycles
  assign drain_len = CW'(n_q) + CW'(m_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    tgt_d   = tgt_q;
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i && !abort_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          n_d     = dim_n_i;
          k_d     = dim_k_i;
          m_d     = dim_m_i;
          tgt_d   = sp_target_i;
        end
        CLEAR: begin
          state_d = FEED;
          cnt_d   = '0;
        end
        FEED: if (cnt_q == CW'(k_q)) begin
          state_d = (drain_len == '0) ? WRITE : DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        DRAIN: if (cnt_q == drain_len - CW'(1)) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        WRITE:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are decoded from the next state so they appear registered with the state
  assign busy_d        = state_d != IDLE;
  assign done_d        = state_d == DONE;
  assign start_err_d   = start_i && !abort_i && state_q != IDLE;
  assign array_clear_d = state_d == CLEAR;
  assign feed_valid_d  = state_d == FEED;
  assign feed_idx_d    = (state_d == FEED) ? cnt_d[DIM_W-1:0] : '0;
  assign sp_we_d       = state_d == WRITE;
  assign sp_addr_d     = (state_d == WRITE) ? tgt_d : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      n_q           <= '0;
      k_q           <= '0;
      m_q           <= '0;
      tgt_q         <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      start_err_o   <= 1'b0;
      array_clear_o <= 1'b0;
      feed_valid_o  <= 1'b0;
      feed_idx_o    <= '0;
      sp_we_o       <= 1'b0;
      sp_addr_o     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      k_q           <= k_d;
      m_q           <= m_d;
      tgt_q         <= tgt_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      start_err_o   <= start_err_d;
      array_clear_o <= array_clear_d;
      feed_valid_o  <= feed_valid_d;
      feed_idx_o    <= feed_idx_d;
      sp_we_o       <= sp_we_d;
      sp_addr_o     <= sp_addr_d;
    end
  end
endmodule
